// File: rtl/gcd_mul_controller.sv
// Sequencing FSM for the x/y coprocessor datapath: runs GCD by repeated
// subtraction or MUL by repeated addition, and returns a registered result.
module gcd_mul_controller #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic             load_x,
  output logic             load_y,
  output logic             subtract_x,
  output logic             subtract_y,
  output logic             add_x,
  output logic             add_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, LOAD, GCD, MUL, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_r, b_r, cnt;
  logic              op_r, ovf, carry;
  logic [ITER_W-1:0] iter;
  logic              zero_gcd, zero_mul;

  // x + a_r carries out of WIDTH bits exactly when x exceeds ~a_r
  assign carry    = (x > ~a_r);
  assign zero_gcd = !op && (a_in == '0 || b_in == '0);
  assign zero_mul = op && (b_in == '0);

  assign x0   = a_r;
  assign y0   = b_r;
  assign busy = (state == LOAD) || (state == GCD) || (state == MUL);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    load_x     = 1'b0;
    load_y     = 1'b0;
    subtract_x = 1'b0;
    subtract_y = 1'b0;
    add_x      = 1'b0;
    add_y      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (zero_gcd || zero_mul) ? DONE : LOAD;
      end
      LOAD: begin
        load_x     = 1'b1;
        load_y     = !op_r;
        state_next = op_r ? MUL : GCD;
      end
      GCD: begin
        if (x == y || iter == ITER_LIMIT) state_next = DONE;
        else if (x > y)                   subtract_x = 1'b1;
        else                              subtract_y = 1'b1;
      end
      MUL: begin
        if (cnt == '0) state_next = DONE;
        else           add_x      = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= 1'b0;
      cnt    <= '0;
      iter   <= '0;
      ovf    <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a_in;
            b_r  <= b_in;
            op_r <= op;
            cnt  <= '0;
            iter <= '0;
            ovf  <= 1'b0;
            if (zero_gcd) begin
              result <= a_in | b_in;
              err    <= (a_in == '0) && (b_in == '0);
            end else if (zero_mul) begin
              result <= '0;
              err    <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (op_r) cnt <= b_r - 1'b1;
        end
        GCD: begin
          if (x == y) begin
            result <= x;
            err    <= 1'b0;
          end else if (iter == ITER_LIMIT) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        MUL: begin
          if (cnt == '0) begin
            result <= x;
            err    <= ovf;
          end else begin
            cnt <= cnt - 1'b1;
            if (carry) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_mul_controller.sv
// Self-checking bench: two controllers (MAX_ITER 255 and 10), each with a
// behavioural x/y datapath, checked against a scoreboard of expected results.
module tb_gcd_mul_controller;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, op, sel;
  logic [W-1:0] a_in, b_in;
  logic         start_b, start_s;

  logic         busy_b, done_b, err_b, lx_b, ly_b, sx_b, sy_b, ax_b, ay_b;
  logic [W-1:0] result_b, x0_b, y0_b, x_b, y_b;
  logic         busy_s, done_s, err_s, lx_s, ly_s, sx_s, sy_s, ax_s, ay_s;
  logic [W-1:0] result_s, x0_s, y0_s, x_s, y_s;

  gcd_mul_controller #(.WIDTH(W), .MAX_ITER(255)) dut (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy_b), .done(done_b), .result(result_b), .err(err_b),
    .x0(x0_b), .y0(y0_b), .load_x(lx_b), .load_y(ly_b),
    .subtract_x(sx_b), .subtract_y(sy_b), .add_x(ax_b), .add_y(ay_b),
    .x(x_b), .y(y_b)
  );

  gcd_mul_controller #(.WIDTH(W), .MAX_ITER(10)) dut_small (
    .clk(clk), .reset(reset), .start(start_s), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy_s), .done(done_s), .result(result_s), .err(err_s),
    .x0(x0_s), .y0(y0_s), .load_x(lx_s), .load_y(ly_s),
    .subtract_x(sx_s), .subtract_y(sy_s), .add_x(ax_s), .add_y(ay_s),
    .x(x_s), .y(y_s)
  );

  // behavioural datapaths: load, subtract the other register, or add the operand
  always_ff @(posedge clk) begin
    if (reset) begin
      x_b <= '0; y_b <= '0; x_s <= '0; y_s <= '0;
    end else begin
      if (lx_b) x_b <= x0_b; else if (sx_b) x_b <= x_b - y_b; else if (ax_b) x_b <= x_b + x0_b;
      if (ly_b) y_b <= y0_b; else if (sy_b) y_b <= y_b - x_b; else if (ay_b) y_b <= y_b + y0_b;
      if (lx_s) x_s <= x0_s; else if (sx_s) x_s <= x_s - y_s; else if (ax_s) x_s <= x_s + x0_s;
      if (ly_s) y_s <= y0_s; else if (sy_s) y_s <= y_s - x_s; else if (ay_s) y_s <= y_s + y0_s;
    end
  end

  logic [5:0] stb_b, stb_s, stb_m;
  logic       busy_m, done_m;
  assign stb_b  = {lx_b, ly_b, sx_b, sy_b, ax_b, ay_b};
  assign stb_s  = {lx_s, ly_s, sx_s, sy_s, ax_s, ay_s};
  assign stb_m  = sel ? stb_s : stb_b;
  assign busy_m = sel ? busy_s : busy_b;
  assign done_m = sel ? done_s : done_b;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           inst;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic [15:0] lx_hist, ly_hist, sx_hist, sy_hist, ax_hist;
  int sx_cnt, sy_cnt, ax_cnt, stb_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int maxi, input int inst);
    exp_t e;
    logic [W-1:0] xm, ym;
    int it, p;
    e.inst = inst;
    if (!o) begin
      if (a == 0 || b == 0) begin
        e.res = a | b; e.err = (a == 0 && b == 0); e.lat = 1;
      end else begin
        xm = a; ym = b; it = 0;
        while (xm != ym && it < maxi) begin
          if (xm > ym) xm = xm - ym; else ym = ym - xm;
          it++;
        end
        e.res = (xm == ym) ? xm : '0;
        e.err = (xm != ym);
        e.lat = 3 + it;
      end
    end else begin
      if (b == 0) begin
        e.res = '0; e.err = 1'b0; e.lat = 1;
      end else begin
        p = int'(a) * int'(b);
        e.res = p[W-1:0];
        e.err = (p > 255);
        e.lat = 2 + int'(b);
      end
    end
    return e;
  endfunction

  // scoreboard consumer plus strobe rules, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (done_b || done_s) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("done_inst", done_s ? 1 : 0, mon_e.inst);
          checkOutput("result", done_s ? result_s : result_b, mon_e.res);
          checkOutput("err", done_s ? err_s : err_b, mon_e.err);
        end
      end
      if ((!busy_b && stb_b != 0) || (!busy_s && stb_s != 0)) viol++;
      if ((32'(lx_b) + 32'(sx_b) + 32'(ax_b)) > 1 || (32'(ly_b) + 32'(sy_b) + 32'(ay_b)) > 1) viol++;
      if ((32'(lx_s) + 32'(sx_s) + 32'(ax_s)) > 1 || (32'(ly_s) + 32'(sy_s) + 32'(ay_s)) > 1) viol++;
    end
  end

  task automatic setStart(input logic v);
    if (sel) start_s = v; else start_b = v;
  endtask

  task automatic pulseJunk();
    op = ~op; a_in = 8'd7; b_in = 8'd7;
    setStart(1'b1);
    @(posedge clk); #1;
    setStart(1'b0);
  endtask

  task automatic applyStimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int pulse_at);
    exp_t e;
    int n;
    e = model(o, a, b, sel ? 10 : 255, sel ? 1 : 0);
    sbq.push_back(e);
    lx_hist = '0; ly_hist = '0; sx_hist = '0; sy_hist = '0; ax_hist = '0;
    sx_cnt = 0; sy_cnt = 0; ax_cnt = 0; stb_cnt = 0;
    @(posedge clk); #1;
    op = o; a_in = a; b_in = b;
    setStart(1'b1);
    @(posedge clk); #1;
    setStart(1'b0);
    n = 1;
    while (1) begin
      if (n < 16) begin
        lx_hist[n] = stb_m[5]; ly_hist[n] = stb_m[4];
        sx_hist[n] = stb_m[3]; sy_hist[n] = stb_m[2]; ax_hist[n] = stb_m[1];
      end
      sx_cnt += int'(stb_m[3]); sy_cnt += int'(stb_m[2]); ax_cnt += int'(stb_m[1]);
      if (stb_m != 0) stb_cnt++;
      if (n == 1) checkOutput("busy_after_accept", busy_m, (e.lat == 1) ? 0 : 1);
      if (done_m || n >= 600) break;
      if (n == pulse_at) pulseJunk();
      else begin @(posedge clk); #1; end
      n++;
    end
    checkOutput("latency", n, e.lat);
    checkOutput("busy_at_done", busy_m, 0);
    if (n == pulse_at) pulseJunk();
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    start_b = 1'b0; start_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy_b, 0);
    checkOutput("rst_done", done_b, 0);
    checkOutput("rst_result", result_b, 0);
    checkOutput("rst_err", err_b, 0);
    checkOutput("rst_x0y0", {x0_b, y0_b}, 0);
    checkOutput("rst_strobes", stb_b, 0);
    reset = 1'b0;

    applyStimulus(1'b0, 8'd12, 8'd8, -1);
    checkOutput("gcd_load_xy", {lx_hist[1], ly_hist[1]}, 2'b11);
    checkOutput("gcd_sub_x_t2", sx_hist[2], 1);
    checkOutput("gcd_sub_y_t3", sy_hist[3], 1);
    checkOutput("gcd_sub_x_t3", sx_hist[3], 0);

    applyStimulus(1'b1, 8'd6, 8'd3, -1);
    checkOutput("mul_load_y", ly_hist[1], 0);
    checkOutput("mul_adds", {ax_hist[2], ax_hist[3], ax_hist[4]}, 3'b110);

    applyStimulus(1'b1, 8'd100, 8'd3, -1);
    applyStimulus(1'b0, 8'd0, 8'd9, -1);
    checkOutput("zero_no_strobes", stb_cnt, 0);
    applyStimulus(1'b0, 8'd0, 8'd0, -1);
    applyStimulus(1'b1, 8'd5, 8'd0, -1);
    applyStimulus(1'b1, 8'd7, 8'd1, -1);

    applyStimulus(1'b0, 8'd255, 8'd1, -1);
    checkOutput("worst_sub_x", sx_cnt, 254);
    checkOutput("worst_sub_y", sy_cnt, 0);

    sel = 1'b1;
    applyStimulus(1'b0, 8'd255, 8'd1, -1);
    checkOutput("timeout_sub_x", sx_cnt, 10);
    applyStimulus(1'b0, 8'd12, 8'd8, -1);
    sel = 1'b0;

    for (int i = 0; i < 8; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), -1);

    applyStimulus(1'b0, 8'd12, 8'd8, 2);
    applyStimulus(1'b1, 8'd6, 8'd3, 5);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ignored_queue_empty", sbq.size(), 0);
    checkOutput("ignored_idle", busy_b, 0);
    checkOutput("result_held", result_b, 18);

    @(posedge clk); #1;
    op = 1'b0; a_in = 8'd255; b_in = 8'd1; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_gcd_busy", busy_b, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_busy", busy_b, 0);
    checkOutput("mid_rst_strobes", stb_b, 0);
    checkOutput("mid_rst_result", result_b, 0);
    checkOutput("mid_rst_done", done_b, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd12, 8'd8, -1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", sbq.size(), 0);
    checkOutput("strobe_rule_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
